prefix_adder_pipe: RTL and testbench

Parametrised, pipelined Sklansky parallel-prefix adder/subtractor with valid/ready flow control. It generalises the fixed-width combinational prefix stages to any power-of-two width. Pipeline registers are inserted every REG_EVERY prefix levels, and an optional flags output is provided. It sits in the execute unit as the ALU add/sub/compare datapath and accepts one operation per cycle when not stalled.

---
 rtl/adder_pkg.sv | 28 ++
 rtl/prefix_adder_pipe_if.sv | 28 ++
 rtl/gp_cell.sv | 12 +
 rtl/prefix_level.sv | 28 ++
 rtl/prefix_adder_pipe.sv | 173 +++++++++++++++++
 tb/tb_prefix_adder_pipe.sv | 279 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/adder_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined prefix adder.
package adder_pkg;

`ifndef LEN_DATA
`define LEN_DATA 32
`endif

  localparam int LEN_DATA = `LEN_DATA;

  // Number of prefix levels for a given operand width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // True when a pipeline register follows prefix level k.
  function automatic bit is_reg_level(input int k, input int reg_every);
    return (k > 0) && ((k % reg_every) == 0);
  endfunction

  // Cycles from the accepting edge to out_valid.
  function automatic int calc_lat(input int width, input int reg_every);
    return 1 + (clog2(width) + reg_every - 1) / reg_every;
  endfunction

endpackage

// File: rtl/prefix_adder_pipe_if.sv
// Operand/result bus of the pipelined prefix adder.
interface prefix_adder_pipe_if #(
  parameter int WIDTH = `LEN_DATA
);
  // Handshake: a beat transfers on a rising edge where valid & ready are both 1;
  // the source holds valid and its payload stable until that edge.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );
endinterface

// File: rtl/gp_cell.sv
// Generate/propagate combining cell: merges a high group with the adjacent low group.
module gp_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);
  assign g = g_hi | (p_hi & g_lo);
  assign p = p_hi & p_lo;
endmodule

// File: rtl/prefix_level.sv
// One combinational Sklansky level: bits with bit (LEVEL-1) of their index set
// combine with the top bit of the group just below; the rest pass through.
module prefix_level #(
  parameter int WIDTH = 32,
  parameter int LEVEL = 1
) (
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] p_out
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (((i >> (LEVEL - 1)) % 2) == 1) begin : g_comb
      localparam int J = ((i >> (LEVEL - 1)) << (LEVEL - 1)) - 1;
      gp_cell u_cell (
        .g_hi (g_in[i]),
        .p_hi (p_in[i]),
        .g_lo (g_in[J]),
        .p_lo (p_in[J]),
        .g    (g_out[i]),
        .p    (p_out[i])
      );
    end else begin : g_pass
      assign g_out[i] = g_in[i];
      assign p_out[i] = p_in[i];
    end
  end
endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Sklansky adder/subtractor with a global-advance valid/ready pipeline.
// Flags (cout/ovf/zero) are built only when ADDER_FLAGS_EN is defined.
module prefix_adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH     = `LEN_DATA,
  parameter int REG_EVERY = 2
) (
  input  logic               clk,
  input  logic               rst,
  prefix_adder_pipe_if.slave bus
);
  localparam int L = clog2(WIDTH);

  logic             adv;
  logic             take;
  logic [WIDTH-1:0] b_x;

  // Every stage moves together; a full output that is not taken freezes all.
  assign adv          = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = adv;
  assign take         = bus.in_valid & adv;
  assign b_x          = bus.in_b ^ {WIDTH{bus.in_sub}};

  logic             s0_v;
  logic [WIDTH-1:0] s0_g;
  logic [WIDTH-1:0] s0_p;
  logic             s0_cin;
`ifdef ADDER_FLAGS_EN
  logic             s0_am;
  logic             s0_bm;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_v   <= 1'b0;
      s0_g   <= '0;
      s0_p   <= '0;
      s0_cin <= 1'b0;
`ifdef ADDER_FLAGS_EN
      s0_am  <= 1'b0;
      s0_bm  <= 1'b0;
`endif
    end else begin
      if (adv) s0_v <= bus.in_valid;
      if (take) begin
        s0_g   <= bus.in_a & b_x;
        s0_p   <= bus.in_a ^ b_x;
        s0_cin <= bus.in_sub;
`ifdef ADDER_FLAGS_EN
        s0_am  <= bus.in_a[WIDTH-1];
        s0_bm  <= b_x[WIDTH-1];
`endif
      end
    end
  end

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    logic [WIDTH-1:0] g_i;
    logic [WIDTH-1:0] p_i;
    logic [WIDTH-1:0] hs_i;
    logic             cin_i;
    logic             v_i;
    logic [WIDTH-1:0] g_o;
    logic [WIDTH-1:0] p_o;
`ifdef ADDER_FLAGS_EN
    logic             am_i;
    logic             bm_i;
`endif

    if (k == 1) begin : g_src
      // Carry-in enters as the generate of bit 0, so G[i] already includes it.
      assign g_i   = {s0_g[WIDTH-1:1], s0_g[0] | (s0_p[0] & s0_cin)};
      assign p_i   = s0_p;
      assign hs_i  = s0_p;
      assign cin_i = s0_cin;
      assign v_i   = s0_v;
`ifdef ADDER_FLAGS_EN
      assign am_i  = s0_am;
      assign bm_i  = s0_bm;
`endif
    end else if (is_reg_level(k - 1, REG_EVERY)) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_i   <= 1'b0;
          g_i   <= '0;
          p_i   <= '0;
          hs_i  <= '0;
          cin_i <= 1'b0;
`ifdef ADDER_FLAGS_EN
          am_i  <= 1'b0;
          bm_i  <= 1'b0;
`endif
        end else begin
          if (adv) v_i <= g_lvl[k-1].v_i;
          if (adv && g_lvl[k-1].v_i) begin
            g_i   <= g_lvl[k-1].g_o;
            p_i   <= g_lvl[k-1].p_o;
            hs_i  <= g_lvl[k-1].hs_i;
            cin_i <= g_lvl[k-1].cin_i;
`ifdef ADDER_FLAGS_EN
            am_i  <= g_lvl[k-1].am_i;
            bm_i  <= g_lvl[k-1].bm_i;
`endif
          end
        end
      end
    end else begin : g_wire
      assign g_i   = g_lvl[k-1].g_o;
      assign p_i   = g_lvl[k-1].p_o;
      assign hs_i  = g_lvl[k-1].hs_i;
      assign cin_i = g_lvl[k-1].cin_i;
      assign v_i   = g_lvl[k-1].v_i;
`ifdef ADDER_FLAGS_EN
      assign am_i  = g_lvl[k-1].am_i;
      assign bm_i  = g_lvl[k-1].bm_i;
`endif
    end

    prefix_level #(
      .WIDTH (WIDTH),
      .LEVEL (k)
    ) u_level (
      .g_in  (g_i),
      .p_in  (p_i),
      .g_out (g_o),
      .p_out (p_o)
    );
  end

  logic [WIDTH-1:0] grp_g;
  logic [WIDTH-1:0] sum_c;
  logic             unused_bits;

  assign grp_g = g_lvl[L].g_o;
  assign sum_c = g_lvl[L].hs_i ^ {grp_g[WIDTH-2:0], g_lvl[L].cin_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
    end else begin
      if (adv) bus.out_valid <= g_lvl[L].v_i;
      if (adv && g_lvl[L].v_i) bus.out_sum <= sum_c;
    end
  end

`ifdef ADDER_FLAGS_EN
  logic ovf_c;
  assign ovf_c = (g_lvl[L].am_i ~^ g_lvl[L].bm_i) & (g_lvl[L].am_i ^ sum_c[WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_cout <= 1'b0;
      bus.out_ovf  <= 1'b0;
      bus.out_zero <= 1'b0;
    end else if (adv && g_lvl[L].v_i) begin
      bus.out_cout <= grp_g[WIDTH-1];
      bus.out_ovf  <= ovf_c;
      bus.out_zero <= ~|sum_c;
    end
  end

  // The last level's group propagate has no consumer.
  assign unused_bits = ^g_lvl[L].p_o;
`else
  assign bus.out_cout = 1'b0;
  assign bus.out_ovf  = 1'b0;
  assign bus.out_zero = 1'b0;
  assign unused_bits  = ^{g_lvl[L].p_o, grp_g[WIDTH-1]};
`endif

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Bench for prefix_adder_pipe: directed vectors on a REG_EVERY=2 instance plus
// shadow instances (REG_EVERY 1,3,4,5) fed the same accepted stream.
module tb_prefix_adder_pipe;
   import adder_pkg::*;

   localparam int W   = 32;
   localparam int RE  = 2;
   localparam int LAT = calc_lat(W, RE);
   localparam int EW  = W + 3;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   cyc;

   prefix_adder_pipe_if #(.WIDTH(W)) bus ();

   prefix_adder_pipe #(.WIDTH(W), .REG_EVERY(RE)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cyc > 20000) begin
         $display("FAIL watchdog: cycle %0d reached, required finish before 20000", cyc);
         $fatal(1);
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks = checks + 1;
      if (obs !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0h required %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [EW-1:0] pack_exp(input logic [W-1:0] s, input logic c,
                                              input logic o, input logic z);
`ifdef ADDER_FLAGS_EN
      return {c, o, z, s};
`else
      return {3'b000, s};
`endif
   endfunction

   function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub);
      logic [W-1:0] bb;
      logic [W:0]   r;
      logic         o;
      bb = sub ? ~b : b;
      r  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
      o  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
      return pack_exp(r[W-1:0], r[W], o, r[W-1:0] == '0);
   endfunction

   // ---------------- scoreboard (primary) ----------------
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] cur_exp;
   int            pop_cnt;
   int            pop_base;
   int            first_pop_cyc;
   int            last_pop_cyc;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("p_unexpected_out", {63'd0, bus.out_valid}, 64'd0);
            end else begin
               check("p_result", {29'd0, bus.out_cout, bus.out_ovf, bus.out_zero, bus.out_sum},
                     {29'd0, exp_q.pop_front()});
               if (pop_cnt == pop_base) first_pop_cyc = cyc;
               last_pop_cyc = cyc;
               pop_cnt = pop_cnt + 1;
            end
         end
         if (bus.in_valid && bus.in_ready) exp_q.push_back(cur_exp);
      end
   end

   // ---------------- shadow instances ----------------
   for (genvar i = 0; i < 4; i++) begin : g_sec
      localparam int SRE = (i == 0) ? 1 : (i == 1) ? 3 : (i == 2) ? 4 : 5;
      prefix_adder_pipe_if #(.WIDTH(W)) sif ();
      logic [EW-1:0] q[$];

      assign sif.in_valid  = bus.in_valid & bus.in_ready;
      assign sif.in_a      = bus.in_a;
      assign sif.in_b      = bus.in_b;
      assign sif.in_sub    = bus.in_sub;
      assign sif.out_ready = 1'b1;

      prefix_adder_pipe #(.WIDTH(W), .REG_EVERY(SRE)) u_sec (
         .clk (clk),
         .rst (rst),
         .bus (sif)
      );

      always @(negedge clk) begin
         if (rst) begin
            q.delete();
         end else begin
            if (sif.out_valid) begin
               if (q.size() == 0)
                  check($sformatf("s%0d_unexpected_out", SRE), {63'd0, sif.out_valid}, 64'd0);
               else
                  check($sformatf("s%0d_result", SRE),
                        {29'd0, sif.out_cout, sif.out_ovf, sif.out_zero, sif.out_sum},
                        {29'd0, q.pop_front()});
            end
            if (sif.in_valid) q.push_back(model(bus.in_a, bus.in_b, bus.in_sub));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic [EW-1:0] e);
      logic acc;
      int   n;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_sub   = sub;
      cur_exp      = e;
      n            = 0;
      acc          = 1'b0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         n = n + 1;
      end
      if (!acc) check("send_timeout", {63'd0, acc}, 64'd1);
      bus.in_valid = 1'b0;
   endtask

   task automatic send_timed(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                             input logic [EW-1:0] e);
      int n;
      send(a, b, sub, e);
      n = 1;
      while (!bus.out_valid && n < 50) begin
         @(posedge clk);
         #1;
         n = n + 1;
      end
      check("latency", n, LAT);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n = n + 1;
      end
      check("drain_empty", exp_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd0);
      check({tag, "_sum"},   {32'd0, bus.out_sum}, 64'd0);
      check({tag, "_flags"}, {61'd0, bus.out_cout, bus.out_ovf, bus.out_zero}, 64'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;
      checks        = 0;
      failures      = 0;
      cyc           = 0;
      pop_cnt       = 0;
      pop_base      = 0;
      first_pop_cyc = 0;
      last_pop_cyc  = 0;
      cur_exp       = '0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_sub    = 1'b0;
      bus.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      check("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed boundary vectors, each into an empty pipe so latency is exact.
      send_timed(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, pack_exp(32'h0000_0000, 1'b1, 1'b0, 1'b1));
      drain();
      send_timed(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, pack_exp(32'h8000_0000, 1'b0, 1'b1, 1'b0));
      drain();
      send_timed(32'd5, 32'd7, 1'b1, pack_exp(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
      drain();
      send_timed(32'd7, 32'd7, 1'b1, pack_exp(32'h0000_0000, 1'b1, 1'b0, 1'b1));
      drain();

      // Back-to-back random stream: one result per cycle, in order.
      pop_base = pop_cnt;
      for (int i = 0; i < 64; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         if (i == 0) rb = ra;
         send(ra, rb, rs, model(ra, rb, rs));
      end
      drain();
      check("stream_count", pop_cnt - pop_base, 64);
      check("stream_span", last_pop_cyc - first_pop_cyc, 63);

      // Stall: fill the pipe with out_ready low, hold 3 cycles, then release with a new op.
      bus.out_ready = 1'b0;
      send(32'd1, 32'd2, 1'b0, pack_exp(32'd3, 1'b0, 1'b0, 1'b0));
      send(32'd10, 32'd3, 1'b1, pack_exp(32'd7, 1'b1, 1'b0, 1'b0));
      send(32'h8000_0000, 32'd1, 1'b1, pack_exp(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
      send(32'd0, 32'd0, 1'b0, pack_exp(32'd0, 1'b0, 1'b0, 1'b1));
      for (int i = 0; i < 3; i++) begin
         check("stall_valid", {63'd0, bus.out_valid}, 64'd1);
         check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
         check("stall_hold", {29'd0, bus.out_cout, bus.out_ovf, bus.out_zero, bus.out_sum},
               {29'd0, pack_exp(32'd3, 1'b0, 1'b0, 1'b0)});
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      send(32'd3, 32'd4, 1'b0, pack_exp(32'd7, 1'b0, 1'b0, 1'b0));
      drain();

      // Reset with three operations in flight.
      for (int i = 0; i < 3; i++) begin
         ra = $urandom;
         rb = $urandom;
         send(ra, rb, 1'b0, model(ra, rb, 1'b0));
      end
      rst = 1'b1;
      #1;
      check_outputs_zero("midreset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_outputs_zero("postreset");
      send_timed(32'h1234_5678, 32'h1111_1111, 1'b1, pack_exp(32'h0123_4567, 1'b1, 1'b0, 1'b0));
      drain();

      repeat (10) @(posedge clk);
      #1;
      check("s1_pending", g_sec[0].q.size(), 0);
      check("s3_pending", g_sec[1].q.size(), 0);
      check("s4_pending", g_sec[2].q.size(), 0);
      check("s5_pending", g_sec[3].q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
